// File: rtl/mb_fetch_if.sv
// Frame-memory read port and 4x4 block output stream of mb_fetch.
// master = fetch unit, slave = memory model / block consumer.
interface mb_fetch_if #(
  parameter int ADDR_W = 24
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              blk_valid;
  logic              blk_ready;
  logic [127:0]      blk_data;
  logic [3:0]        blk_idx;
  logic [12:0]       mbnumber;

  modport master (
    output mem_req, mem_addr, blk_valid, blk_data, blk_idx, mbnumber,
    input  mem_gnt, mem_rvalid, mem_rdata, blk_ready
  );
  modport slave (
    input  mem_req, mem_addr, blk_valid, blk_data, blk_idx, mbnumber,
    output mem_gnt, mem_rvalid, mem_rdata, blk_ready
  );
endinterface

// File: rtl/mb_fetch.sv
// mb_fetch: walks a raster frame MB by MB, reads each 16x16 luma MB into a
// ping-pong buffer and streams it out as sixteen 4x4 blocks in H.264 scan
// order. The fetch of MB n+1 overlaps the output of MB n.
// Optional: MB_FETCH_AVAIL_EN adds mb_left_avail / mb_top_avail outputs.
module mb_fetch #(
  parameter int FRAME_W_MB = 120,
  parameter int FRAME_H_MB = 68,
  parameter int ADDR_W     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  output logic       busy,
  output logic       done,
  mb_fetch_if.master bus
`ifdef MB_FETCH_AVAIL_EN
  ,
  output logic       mb_left_avail,
  output logic       mb_top_avail
`endif
);
  localparam int          MBX_W      = (FRAME_W_MB > 1) ? $clog2(FRAME_W_MB) : 1;
  localparam int          MBY_W      = (FRAME_H_MB > 1) ? $clog2(FRAME_H_MB) : 1;
  localparam int          LINE_WORDS = FRAME_W_MB * 4;
  localparam logic [12:0] LAST_MB    = 13'(FRAME_W_MB * FRAME_H_MB - 1);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fstate_t;
  typedef enum logic       {O_IDLE, O_SEND}        ostate_t;

  fstate_t fstate, fstate_nx;
  ostate_t ostate, ostate_nx;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [5:0]        rcnt;      // grants issued for the MB being fetched
  logic [5:0]        wcnt;      // words landed in the fill bank
  logic [6:0]        outst;     // granted but not yet returned
  logic [MBX_W-1:0]  fmbx;
  logic [MBY_W-1:0]  fmby;
  logic              fbank, obank;
  logic [1:0]        full;
  logic [31:0]       bank_mem [2][64];

  logic              blk_valid;
  logic [127:0]      blk_data;
  logic [3:0]        blk_idx;
  logic [12:0]       mbnumber;

  logic              start_acc, grant, wr, fill_done, flast, f_adv;
  logic              accept, last_k, free, olast, idle_avail, next_avail;
  logic              rd_bank;
  logic [3:0]        rd_k;
  logic [127:0]      rd_blk;

  assign start_acc  = start & ~busy;
  assign grant      = mem_req & bus.mem_gnt;
  // Returns with nothing outstanding belong to a pre-reset frame: drop them.
  assign wr         = bus.mem_rvalid & (outst != 7'd0);
  assign fill_done  = wr & (wcnt == 6'd63);
  assign flast      = (fmbx == MBX_W'(FRAME_W_MB - 1)) && (fmby == MBY_W'(FRAME_H_MB - 1));
  assign accept     = blk_valid & bus.blk_ready;
  assign last_k     = (blk_idx == 4'd15);
  assign free       = accept & last_k;
  assign olast      = (mbnumber == LAST_MB);
  // A bank counts as ready in the same cycle its last word lands, so
  // blk_valid follows a completed fill by one cycle.
  assign idle_avail = full[obank]  | (fill_done & (fbank == obank));
  assign next_avail = full[~obank] | (fill_done & (fbank != obank));

  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.blk_valid = blk_valid;
  assign bus.blk_data  = blk_data;
  assign bus.blk_idx   = blk_idx;
  assign bus.mbnumber  = mbnumber;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [MBY_W-1:0] my,
                                                input logic [MBX_W-1:0] mx,
                                                input logic [5:0]       n);
    logic [ADDR_W-1:0] line;
    line = (ADDR_W'(my) << 4) + ADDR_W'(n[5:2]);
    return line * ADDR_W'(LINE_WORDS) + (ADDR_W'(mx) << 2) + ADDR_W'(n[1:0]);
  endfunction

  // State registers for both FSMs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate <= F_IDLE;
      ostate <= O_IDLE;
    end else begin
      fstate <= fstate_nx;
      ostate <= ostate_nx;
    end
  end

  // Fetch next state; f_adv moves the fetch to the next MB and bank.
  always_comb begin
    fstate_nx = fstate;
    f_adv     = 1'b0;
    unique case (fstate)
      F_IDLE: if (start_acc) fstate_nx = F_REQ;
      F_REQ:  if (grant && rcnt == 6'd63) fstate_nx = F_WAIT;
      F_WAIT: if (full[fbank]) begin
        if (flast) fstate_nx = F_IDLE;
        else if (!full[~fbank]) begin
          fstate_nx = F_REQ;
          f_adv     = 1'b1;
        end
      end
      default: fstate_nx = F_IDLE;
    endcase
  end

  // Request issue: a raised request holds its address until granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rcnt     <= '0;
      wcnt     <= '0;
      outst    <= '0;
      fmbx     <= '0;
      fmby     <= '0;
      fbank    <= 1'b0;
    end else begin
      outst <= outst + 7'(grant) - 7'(wr);
      if (wr) wcnt <= wcnt + 6'd1;
      if (start_acc) begin
        fmbx  <= '0;
        fmby  <= '0;
        fbank <= 1'b0;
        rcnt  <= '0;
      end else if (f_adv) begin
        fbank <= ~fbank;
        rcnt  <= '0;
        if (fmbx == MBX_W'(FRAME_W_MB - 1)) begin
          fmbx <= '0;
          fmby <= fmby + MBY_W'(1);
        end else begin
          fmbx <= fmbx + MBX_W'(1);
        end
      end
      if (fstate == F_REQ) begin
        if (grant) begin
          rcnt     <= rcnt + 6'd1;
          mem_req  <= enable && (rcnt != 6'd63);
          mem_addr <= addr_of(fmby, fmbx, rcnt + 6'd1);
        end else if (!mem_req && enable) begin
          mem_req  <= 1'b1;
          mem_addr <= addr_of(fmby, fmbx, rcnt);
        end
      end
    end
  end

  // Bank occupancy: set on the 64th return, cleared when block 15 is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (fill_done && fbank == 1'(b))   full[b] <= 1'b1;
        else if (free && obank == 1'(b))   full[b] <= 1'b0;
      end
    end
  end

  // Buffer storage: returned words land in arrival (raster) order.
  always_ff @(posedge clk) begin
    if (wr) bank_mem[fbank][wcnt] <= bus.mem_rdata;
  end

  // Output next state and which block to load next.
  always_comb begin
    ostate_nx = ostate;
    rd_bank   = obank;
    rd_k      = blk_idx + 4'd1;
    unique case (ostate)
      O_IDLE: begin
        rd_k = 4'd0;
        if (idle_avail) ostate_nx = O_SEND;
      end
      O_SEND: if (free) begin
        rd_bank = ~obank;
        rd_k    = 4'd0;
        if (olast || !next_avail) ostate_nx = O_IDLE;
      end
    endcase
  end

  // Gather a 4x4 block: x4={k[2],k[0]} picks the word, y4={k[3],k[1]} the row band.
  always_comb begin
    rd_blk = '0;
    for (int r = 0; r < 4; r++)
      rd_blk[32*r +: 32] = bank_mem[rd_bank][{rd_k[3], rd_k[1], 2'(r), rd_k[2], rd_k[0]}];
  end

  // Block output registers, MB counter, busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_idx   <= '0;
      mbnumber  <= '0;
      obank     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        busy  <= 1'b1;
        obank <= 1'b0;
      end
      if (ostate == O_IDLE) begin
        if (idle_avail) begin
          blk_valid <= 1'b1;
          blk_idx   <= 4'd0;
          blk_data  <= rd_blk;
        end
      end else if (accept) begin
        if (!last_k) begin
          blk_idx  <= blk_idx + 4'd1;
          blk_data <= rd_blk;
        end else begin
          obank   <= ~obank;
          blk_idx <= 4'd0;
          if (olast) begin
            blk_valid <= 1'b0;
            mbnumber  <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            mbnumber <= mbnumber + 13'd1;
            if (next_avail) blk_data  <= rd_blk;
            else            blk_valid <= 1'b0;
          end
        end
      end
    end
  end

`ifdef MB_FETCH_AVAIL_EN
  logic [MBX_W-1:0] omx;

  // Neighbour availability tracks the output MB, updated with mbnumber.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      omx           <= '0;
      mb_left_avail <= 1'b0;
      mb_top_avail  <= 1'b0;
    end else if (start_acc || (free && olast)) begin
      omx           <= '0;
      mb_left_avail <= 1'b0;
      mb_top_avail  <= 1'b0;
    end else if (free) begin
      if (omx == MBX_W'(FRAME_W_MB - 1)) begin
        omx           <= '0;
        mb_left_avail <= 1'b0;
        mb_top_avail  <= 1'b1;
      end else begin
        omx           <= omx + MBX_W'(1);
        mb_left_avail <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mb_fetch.sv
// Directed bench for mb_fetch on a 2x2-MB frame.
module tb_mb_fetch;
  logic clk = 1'b0;
  logic rst_n, enable, start, busy, done;
`ifdef MB_FETCH_AVAIL_EN
  logic left_av, top_av;
`endif

  mb_fetch_if #(.ADDR_W(24)) bus();

  mb_fetch #(.FRAME_W_MB(2), .FRAME_H_MB(2), .ADDR_W(24)) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .start(start),
    .busy(busy), .done(done), .bus(bus)
`ifdef MB_FETCH_AVAIL_EN
    , .mb_left_avail(left_av), .mb_top_avail(top_av)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_t = 0;
  bit rnd = 1'b0;
  logic [23:0]  mq_a[$];
  int           mq_t[$];
  logic [23:0]  gnt_log[$];
  logic [127:0] ob_data[$];
  logic [3:0]   ob_idx[$];
  logic [12:0]  ob_mb[$];
  logic [1:0]   ob_av[$];
  int done_cnt = 0;

  function automatic logic [31:0] mword(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [127:0] exp_blk(input int m, input logic [3:0] k);
    int mbx, mby, x4, y4;
    logic [127:0] d;
    mbx = m % 2;
    mby = m / 2;
    x4 = int'(k[2]) * 2 + int'(k[0]);
    y4 = int'(k[3]) * 2 + int'(k[1]);
    d = '0;
    for (int r = 0; r < 4; r++)
      d[32*r +: 32] = mword(24'((mby*16 + y4*4 + r)*8 + mbx*4 + x4));
    return d;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order returns, latency 1 or random 1..8, optional random grant.
  always @(negedge clk) begin
    int t;
    cyc++;
    if (!rst_n) begin
      mq_a.delete(); mq_t.delete(); last_t = 0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    end else begin
      if (mq_t.size() > 0 && mq_t[0] <= cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mword(mq_a[0]);
        void'(mq_a.pop_front());
        void'(mq_t.pop_front());
      end else begin
        bus.mem_rvalid = 1'b0;
      end
      bus.mem_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.mem_req && bus.mem_gnt) begin
        t = rnd ? cyc + int'($urandom_range(1, 8)) : cyc + 1;
        if (t <= last_t) t = last_t + 1;
        last_t = t;
        mq_a.push_back(bus.mem_addr);
        mq_t.push_back(t);
        gnt_log.push_back(bus.mem_addr);
      end
    end
  end

  // Block monitor: records each handshake and counts done pulses.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (bus.blk_valid && bus.blk_ready) begin
        ob_data.push_back(bus.blk_data);
        ob_idx.push_back(bus.blk_idx);
        ob_mb.push_back(bus.mbnumber);
`ifdef MB_FETCH_AVAIL_EN
        ob_av.push_back({left_av, top_av});
`else
        ob_av.push_back(2'b00);
`endif
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    ob_data.delete(); ob_idx.delete(); ob_mb.delete(); ob_av.delete();
    gnt_log.delete(); done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 160'(n < 5000), 160'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_blk(input string tag, input logic [12:0] mb, input logic [3:0] k);
    int n = 0;
    while (!(bus.blk_valid && bus.mbnumber == mb && bus.blk_idx == k) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk({tag, "_timeout"}, 160'(n < 5000), 160'(1));
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_count"}, 160'(ob_data.size()), 160'(64));
    chk({tag, "_done_pulses"}, 160'(done_cnt), 160'(1));
    chk({tag, "_busy_end"}, 160'(busy), 160'(0));
    chk({tag, "_mbn_end"}, 160'(bus.mbnumber), 160'(0));
    n = (ob_data.size() < 64) ? ob_data.size() : 64;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_blk%0d", tag, i), {ob_mb[i], ob_idx[i], ob_data[i]},
          {13'(i / 16), 4'(i % 16), exp_blk(i / 16, 4'(i % 16))});
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] hold_d;
    logic [1:0]   exp_av [4];
    exp_av = '{2'b00, 2'b10, 2'b01, 2'b11};
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; bus.blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  160'(busy), 160'(0));
    chk("rst_done",  160'(done), 160'(0));
    chk("rst_req",   160'(bus.mem_req), 160'(0));
    chk("rst_addr",  160'(bus.mem_addr), 160'(0));
    chk("rst_valid", 160'(bus.blk_valid), 160'(0));
    chk("rst_data",  160'(bus.blk_data), 160'(0));
    chk("rst_idx",   160'(bus.blk_idx), 160'(0));
    chk("rst_mbn",   160'(bus.mbnumber), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: plain frame, always-ready consumer.
    clear_logs();
    pulse_start();
    chk("t1_busy", 160'(busy), 160'(1));
    wait_done("t1");
    check_frame("t1");
    d = ob_data[0];  chk("t1_k0_row0", 160'(d[31:0]), 160'(32'h03020100));
    chk("t1_k0_row1", 160'(d[63:32]), 160'(32'h0b0a0908));
    d = ob_data[1];  chk("t1_k1_row0", 160'(d[31:0]), 160'(32'h04030201));
    d = ob_data[2];  chk("t1_k2_row0", 160'(d[31:0]), 160'(32'h23222120));
    d = ob_data[16]; chk("t1_mb1_k0_row0", 160'(d[31:0]), 160'(32'h07060504));
    d = ob_data[63]; chk("t1_mb3_k15_row3", 160'(d[127:96]), 160'(32'h020100ff));
    chk("t1_addr64", 160'(gnt_log.size()), 160'(256));
`ifdef MB_FETCH_AVAIL_EN
    for (int m = 0; m < 4; m++)
      chk($sformatf("t6_avail_mb%0d", m), 160'(ob_av[m*16]), 160'(exp_av[m]));
`endif

    // Test 2: backpressure on MB1 block 7.
    clear_logs();
    pulse_start();
    wait_blk("t2_find", 13'd1, 4'd7);
    bus.blk_ready = 1'b0;
    hold_d = bus.blk_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t2_hold%0d", c), {bus.blk_valid, bus.blk_idx, bus.mbnumber, bus.blk_data},
          {1'b1, 4'd7, 13'd1, hold_d});
    end
    bus.blk_ready = 1'b1;
    wait_done("t2");
    check_frame("t2");

    // Tests 3+4: random grant/latency, enable pause, ignored mid-frame start.
    clear_logs();
    rnd = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    chk("t3_pause_req", 160'(bus.mem_req), 160'(0));
    enable = 1'b1;
    wait_blk("t4_find", 13'd1, 4'd0);
    pulse_start();
    chk("t4_busy", 160'(busy), 160'(1));
    wait_done("t3");
    check_frame("t3");
    chk("t3_addr_count", 160'(gnt_log.size()), 160'(256));
    if (gnt_log.size() >= 129) begin
      for (int i = 0; i < 64; i++)
        chk($sformatf("t3_addr%0d", i), 160'(gnt_log[i]), 160'((i / 4) * 8 + (i % 4)));
      chk("t3_addr_mb1", 160'(gnt_log[64]), 160'(4));
      chk("t3_addr_mb2", 160'(gnt_log[128]), 160'(128));
    end
    rnd = 1'b0;

    // Test 5: reset in the middle of MB2, then a fresh frame.
    clear_logs();
    pulse_start();
    wait_blk("t5_find", 13'd2, 4'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {busy, done, bus.mem_req, bus.blk_valid, bus.blk_idx, bus.mbnumber},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 13'd0});
    chk("t5_rst_addr", 160'(bus.mem_addr), 160'(0));
    chk("t5_rst_data", 160'(bus.blk_data), 160'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    pulse_start();
    wait_done("t5");
    check_frame("t5");
    if (gnt_log.size() > 0) chk("t5_first_addr", 160'(gnt_log[0]), 160'(0));
    else chk("t5_first_addr_missing", 160'(gnt_log.size()), 160'(256));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
